// File: rtl/beat_note_reader_pkg.sv
// Shared types and defaults for the beat note reader.
// Latency: none (declarations only). Backpressure: n/a.
// Holds bus-width defaults, the rest-flag position and the fetch FSM states.
package beat_note_reader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int NOTE_W_DEF = 8;
    localparam int REST_BIT   = NOTE_W_DEF - 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESENT
    } state_t;

    // The rest flag always sits in the top bit of a pattern word.
    function automatic int rest_bit(input int note_w);
        return note_w - 1;
    endfunction

endpackage

// File: rtl/beat_note_reader_gate_timer.sv
// Note gate: high for GATE_CYCLES cycles starting the cycle after trigger.
// Latency: 1 cycle trigger -> gate. Backpressure: none, a trigger is never refused.
// A trigger while the gate is high forces one low cycle before the fresh gate.
module gate_timer #(
    parameter logic [31:0] GATE_CYCLES = 32'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic gate
);
    localparam logic [31:0] RELOAD = GATE_CYCLES - 32'd1;

    logic [31:0] remain;
    logic        gap;

    always_ff @(posedge clk) begin
        if (reset) begin
            gate   <= 1'b0;
            remain <= '0;
            gap    <= 1'b0;
        end else if (trigger && !gate) begin
            gate   <= 1'b1;
            remain <= RELOAD;
            gap    <= 1'b0;
        end else if (gap) begin
            gate   <= 1'b1;
            remain <= RELOAD;
            gap    <= 1'b0;
        end else if (trigger) begin
            // Retrigger: envelope must see a key-up edge before the new note.
            gate <= 1'b0;
            gap  <= 1'b1;
        end else if (gate) begin
            if (remain == '0) begin
                gate <= 1'b0;
            end else begin
                remain <= remain - 32'd1;
            end
        end
    end

endmodule

// File: rtl/beat_note_reader.sv
// Fetches the pattern word for each new beat address and offers the note to the voice.
// Latency: beat_addr change -> note_valid is RAM_LATENCY+2 cycles.
// Backpressure: note held until note_ready; newer addresses wait in a one-deep slot.
module beat_note_reader
    import beat_note_reader_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          NOTE_W      = NOTE_W_DEF,
    parameter int          RAM_LATENCY = 1,
    parameter logic [31:0] GATE_CYCLES = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] beat_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-2:0] note_out,
    output logic              note_valid,
    input  logic              note_ready,
    output logic              gate
);
    localparam int         REST = rest_bit(NOTE_W);
    localparam logic [2:0] LAT  = 3'(RAM_LATENCY);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] last_addr, pend_addr, fetch_addr;
    logic              addr_seen, pend_vld;
    logic              req, fetch_go, capture, is_rest, handshake, gate_clr;
    logic [2:0]        wait_cnt;

    assign req       = !addr_seen || (beat_addr != last_addr);
    assign handshake = note_valid && note_ready;
    assign is_rest   = mem_rdata[REST];
    assign gate_clr  = reset || (capture && is_rest);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fetch_go   = 1'b0;
        fetch_addr = beat_addr;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                // A live change always beats the parked address: it is newer.
                if (req) begin
                    fetch_go  = 1'b1;
                    state_nxt = WAIT;
                end else if (pend_vld) begin
                    fetch_go   = 1'b1;
                    fetch_addr = pend_addr;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == LAT) begin
                    capture   = 1'b1;
                    state_nxt = is_rest ? IDLE : PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr  <= '0;
            addr_seen  <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            wait_cnt   <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
        end else begin
            last_addr <= beat_addr;
            addr_seen <= 1'b1;
            mem_rd_en <= fetch_go;

            if (fetch_go) begin
                mem_addr <= fetch_addr;
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end

            if (state == IDLE) begin
                pend_vld <= 1'b0;
            end else if (req) begin
                pend_vld  <= 1'b1;
                pend_addr <= beat_addr;
            end

            if (capture && !is_rest) begin
                note_out   <= mem_rdata[NOTE_W-2:0];
                note_valid <= 1'b1;
            end else if (handshake) begin
                note_valid <= 1'b0;
            end
        end
    end

    gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate_timer (
        .clk    (clk),
        .reset  (gate_clr),
        .trigger(handshake),
        .gate   (gate)
    );

endmodule

// File: tb/tb_beat_note_reader.sv
// Directed bench for beat_note_reader: table of single fetches plus hand-written
// sequences for backpressure, retrigger, rest gate-kill and mid-operation reset.
module tb_beat_note_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] beat_addr;
    logic [9:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = 8'h00;
    logic [6:0] note_out;
    logic       note_valid;
    logic       note_ready;
    logic       gate;

    always #5 clk = ~clk;

    beat_note_reader dut (
        .clk       (clk),
        .reset     (reset),
        .beat_addr (beat_addr),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .note_out  (note_out),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .gate      (gate)
    );

    // Pattern RAM with one cycle of read latency.
    logic [7:0] ram [1024];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    // Per-run trace: bit k of each mask = output high after the k-th edge.
    logic [31:0] rd_m, nv_m, g_m;
    int          k;
    logic [9:0]  addr_at [32];
    logic [6:0]  note_at [32];

    typedef struct {
        logic [9:0]  addr;
        logic [7:0]  data;
        logic [6:0]  note;
        logic [31:0] nv;
        logic [31:0] g;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        rd_m = '0;
        nv_m = '0;
        g_m  = '0;
        k    = 0;
    endtask

    task automatic step(input logic rst, input logic rdy, input logic [9:0] a);
        reset      = rst;
        note_ready = rdy;
        beat_addr  = a;
        @(posedge clk);
        #1;
        k++;
        if (mem_rd_en)  rd_m[k] = 1'b1;
        if (note_valid) nv_m[k] = 1'b1;
        if (gate)       g_m[k]  = 1'b1;
        addr_at[k] = mem_addr;
        note_at[k] = note_out;
    endtask

    initial begin
        int stable;
        reset      = 1'b1;
        note_ready = 1'b1;
        beat_addr  = 10'd5;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[5] = 8'h3C;

        vecs[0] = '{10'd6,    8'hBC, 7'h00, 32'h0, 32'h0};
        vecs[1] = '{10'd7,    8'h01, 7'h01, 32'h8, 32'hF0};
        vecs[2] = '{10'd1023, 8'h7F, 7'h7F, 32'h8, 32'hF0};
        vecs[3] = '{10'd0,    8'h80, 7'h00, 32'h0, 32'h0};
        vecs[4] = '{10'd3,    8'h00, 7'h00, 32'h8, 32'hF0};
        for (int i = 0; i < 5; i++) ram[vecs[i].addr] = vecs[i].data;

        // Reset held three cycles: every output low.
        clear_log();
        repeat (3) begin
            step(1'b1, 1'b1, 10'd5);
            chk("reset_outs", {12'h0, mem_addr, mem_rd_en, note_out, note_valid, gate}, 32'h0);
        end

        // First address after release is fetched; note 0x3C, gate 4 cycles.
        clear_log();
        repeat (12) step(1'b0, 1'b1, 10'd5);
        chk("first_rd", rd_m, 32'h2);
        chk("first_addr", {22'h0, addr_at[1]}, 32'd5);
        chk("first_nv", nv_m, 32'h8);
        chk("first_note", {25'h0, note_at[3]}, 32'h3C);
        chk("first_gate", g_m, 32'hF0);

        for (int i = 0; i < 5; i++) begin
            clear_log();
            repeat (12) step(1'b0, 1'b1, vecs[i].addr);
            chk($sformatf("row%0d_rd", i), rd_m, 32'h2);
            chk($sformatf("row%0d_addr", i), {22'h0, addr_at[1]}, {22'h0, vecs[i].addr});
            chk($sformatf("row%0d_nv", i), nv_m, vecs[i].nv);
            if (vecs[i].nv != 0)
                chk($sformatf("row%0d_note", i), {25'h0, note_at[3]}, {25'h0, vecs[i].note});
            chk($sformatf("row%0d_gate", i), g_m, vecs[i].g);
        end

        // Ready low 10 cycles while address moves 5->6->7; then retrigger.
        clear_log();
        repeat (4) step(1'b0, 1'b0, 10'd5);
        step(1'b0, 1'b0, 10'd6);
        repeat (5) step(1'b0, 1'b0, 10'd7);
        repeat (15) step(1'b0, 1'b1, 10'd7);
        stable = 0;
        for (int j = 3; j <= 10; j++) if (note_at[j] == 7'h3C) stable++;
        chk("hold_rd", rd_m, 32'h1002);
        chk("hold_pend_addr", {22'h0, addr_at[12]}, 32'd7);
        chk("hold_nv", nv_m, 32'h47F8);
        chk("hold_note_stable", stable, 32'd8);
        chk("hold_note2", {25'h0, note_at[14]}, 32'h01);
        chk("retrig_gate", g_m, 32'hF7800);

        // Reset while in WAIT: fetch abandoned, same address refetched.
        clear_log();
        step(1'b0, 1'b1, 10'd1023);
        step(1'b1, 1'b1, 10'd1023);
        repeat (10) step(1'b0, 1'b1, 10'd1023);
        chk("rst_wait_rd", rd_m, 32'hA);
        chk("rst_wait_addr", {22'h0, addr_at[3]}, 32'd1023);
        chk("rst_wait_nv", nv_m, 32'h20);
        chk("rst_wait_note", {25'h0, note_at[5]}, 32'h7F);
        chk("rst_wait_gate", g_m, 32'h3C0);

        // Reset while in PRESENT with a parked address: parked address dropped.
        clear_log();
        repeat (3) step(1'b0, 1'b0, 10'd7);
        step(1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        repeat (9) step(1'b0, 1'b1, 10'd3);
        chk("rst_pres_rd", rd_m, 32'h42);
        chk("rst_pres_addr", {22'h0, addr_at[6]}, 32'd3);
        chk("rst_pres_nv", nv_m, 32'h118);
        chk("rst_pres_gate", g_m, 32'h1E00);

        // Reset while the gate is high drops it on the next cycle.
        clear_log();
        repeat (4) step(1'b0, 1'b1, 10'd5);
        step(1'b1, 1'b1, 10'd5);
        repeat (7) step(1'b0, 1'b1, 10'd5);
        chk("rst_gate_rd", rd_m, 32'h42);
        chk("rst_gate_nv", nv_m, 32'h108);
        chk("rst_gate_gate", g_m, 32'h1E10);

        // Rest word fetched while gate is high cuts the gate short.
        clear_log();
        repeat (3) step(1'b0, 1'b1, 10'd7);
        repeat (7) step(1'b0, 1'b1, 10'd6);
        chk("rest_kill_rd", rd_m, 32'h22);
        chk("rest_kill_addr", {22'h0, addr_at[5]}, 32'd6);
        chk("rest_kill_nv", nv_m, 32'h8);
        chk("rest_kill_gate", g_m, 32'h70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
